// File: rtl/key_expansion_pkg.sv
// Shared types and constants for the AES-128 key schedule: state encoding,
// S-box table and round-constant lookup.
package key_expansion_pkg;

  localparam int W_KEY          = 128;
  localparam int NUM_ROUNDS_128 = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant applied when deriving round r+1 from round r.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Key-load and round-key stream bundle; the optional store read port exists
// only when KEYEXP_STORE_EN is defined.
interface key_expansion_if #(
  parameter int W_ROUND = 4
);
  logic                                 load_valid;
  logic                                 load_ready;
  logic [key_expansion_pkg::W_KEY-1:0]  key_in;
  logic                                 rk_valid;
  logic                                 rk_ready;
  logic [key_expansion_pkg::W_KEY-1:0]  rk_data;
  logic [W_ROUND-1:0]                   rk_round;
  logic                                 done;
`ifdef KEYEXP_STORE_EN
  logic                                 rd_en;
  logic [W_ROUND-1:0]                   rd_round;
  logic [key_expansion_pkg::W_KEY-1:0]  rd_key;
  logic                                 rd_valid;
  logic                                 store_valid;

  modport master (
    output load_valid, key_in, rk_ready, rd_en, rd_round,
    input  load_ready, rk_valid, rk_data, rk_round, done, rd_key, rd_valid, store_valid
  );
  modport slave (
    input  load_valid, key_in, rk_ready, rd_en, rd_round,
    output load_ready, rk_valid, rk_data, rk_round, done, rd_key, rd_valid, store_valid
  );
`else
  modport master (
    output load_valid, key_in, rk_ready,
    input  load_ready, rk_valid, rk_data, rk_round, done
  );
  modport slave (
    input  load_valid, key_in, rk_ready,
    output load_ready, rk_valid, rk_data, rk_round, done
  );
`endif
endinterface

// File: rtl/key_expansion_sbox.sv
// Combinational AES forward S-box for one byte; four of these form SubWord.
module aes_sbox
  import key_expansion_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);
  assign subst = SBOX[value];
endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: streams round keys 0..NUM_ROUNDS, one per rk handshake; round 0 valid the
// cycle after load, rk_data/rk_round hold while stalled. KEYEXP_STORE_EN adds a random-access store.
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_128,
  parameter int W_ROUND    = 4
) (
  input  logic          clk,
  input  logic          reset,
  key_expansion_if.slave bus
);

  state_t               state, state_next;
  logic [W_KEY-1:0]     cur_key;
  logic [W_KEY-1:0]     next_key;
  logic [W_ROUND-1:0]   round;
  logic                 last;
  logic                 load_take;
  logic                 rk_take;
  logic                 load_ready;
  logic                 rk_valid;
  logic                 done;

  // Next round key: one SubWord(RotWord(w3)) per step, then the xor chain.
  logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  assign w0  = cur_key[127:96];
  assign w1  = cur_key[95:64];
  assign w2  = cur_key[63:32];
  assign w3  = cur_key[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .value (rot[gi*8 +: 8]),
      .subst (sub[gi*8 +: 8])
    );
  end

  assign t        = sub ^ {rcon(4'(round)), 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign last = (round == W_ROUND'(NUM_ROUNDS));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    rk_valid   = 1'b0;
    done       = 1'b0;
    load_take  = 1'b0;
    rk_take    = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          load_take  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_valid = 1'b1;
        if (bus.rk_ready) begin
          rk_take = 1'b1;
          if (last) begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_key <= '0;
      round   <= '0;
    end else if (load_take) begin
      cur_key <= bus.key_in;
      round   <= '0;
    end else if (rk_take && !last) begin
      cur_key <= next_key;
      round   <= round + 1'b1;
    end
  end

  // An abandoned expansion must never report completion.
  assign bus.load_ready = load_ready;
  assign bus.rk_valid   = rk_valid;
  assign bus.done       = done & ~reset;
  assign bus.rk_data    = (state == ST_RUN) ? cur_key : '0;
  assign bus.rk_round   = (state == ST_RUN) ? round   : '0;

`ifdef KEYEXP_STORE_EN
  logic [W_KEY-1:0] store [NUM_ROUNDS+1];
  logic             store_valid;
  logic             rd_valid;
  logic [W_KEY-1:0] rd_key;
  logic             rd_ok;

  always_ff @(posedge clk) begin
    if (state == ST_RUN) store[round] <= cur_key;
  end

  assign rd_ok = store_valid && (bus.rd_round <= W_ROUND'(NUM_ROUNDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      store_valid <= 1'b0;
      rd_valid    <= 1'b0;
      rd_key      <= '0;
    end else begin
      if (load_take)            store_valid <= 1'b0;
      else if (done)            store_valid <= 1'b1;
      rd_valid <= bus.rd_en && rd_ok;
      if (bus.rd_en) rd_key <= rd_ok ? store[bus.rd_round] : '0;
    end
  end

  assign bus.store_valid = store_valid;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_key      = rd_key;
`endif

endmodule
